// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencing FSM: digit entry and compare, failure counting, alarm hold,
// timed open state with relock, and password change through a shadow buffer.
module combo_lock_ctrl #(
  parameter int                          DIGITS      = 4,
  parameter int                          DIGIT_W     = 4,
  parameter int                          MAX_FAILS   = 3,
  parameter int                          OPEN_TICKS  = 50000000,
  parameter int                          ALARM_TICKS = 100000000,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_PW  = 16'h1234
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             digit_valid,
  input  logic                             clear,
  input  logic                             set_pw,
  input  logic                             lock,
  output logic [2:0]                       state,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic                             unlocked
);

  localparam int FC_W   = $clog2(MAX_FAILS + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int T_MAX  = (OPEN_TICKS > ALARM_TICKS) ? OPEN_TICKS : ALARM_TICKS;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_TICKS - 1);
  localparam logic [TMR_W-1:0] ALARM_LOAD = TMR_W'(ALARM_TICKS - 1);
  localparam logic [FC_W-1:0]  FC_MAX     = FC_W'(MAX_FAILS);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_ENTRY = 3'b001,
    S_ALARM = 3'b010,
    S_NEWPW = 3'b011,
    S_OPEN  = 3'b100
  } state_t;

  typedef logic [DIGITS-1:0][DIGIT_W-1:0] pw_t;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic             r_mis, w_mis_next;
  logic [FC_W-1:0]  r_fail, w_fail_next;
  logic [TMR_W-1:0] r_timer, w_timer_next;
  pw_t              r_pw, w_pw_next;
  pw_t              r_shadow, w_shadow_next;
  logic             r_unlocked;

  logic             w_digit_mis;
  logic             w_eval;
  logic             w_eval_mis;

  assign w_digit_mis = (digit_in != r_pw[r_idx]);

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_mis_next    = r_mis;
    w_fail_next   = r_fail;
    w_timer_next  = r_timer;
    w_pw_next     = r_pw;
    w_shadow_next = r_shadow;
    w_eval        = 1'b0;
    w_eval_mis    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_idx_next = '0;
          w_mis_next = 1'b0;
        end else if (digit_valid) begin
          if (DIGITS == 1) begin
            w_eval     = 1'b1;
            w_eval_mis = w_digit_mis;
          end else begin
            w_state_next = S_ENTRY;
            w_idx_next   = IDX_W'(1);
            w_mis_next   = w_digit_mis;
          end
        end
      end
      S_ENTRY: begin
        if (clear) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
          w_mis_next   = 1'b0;
        end else if (digit_valid) begin
          if (r_idx == IDX_LAST) begin
            w_eval     = 1'b1;
            w_eval_mis = r_mis | w_digit_mis;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
            w_mis_next = r_mis | w_digit_mis;
          end
        end
      end
      S_OPEN: begin
        if (lock) begin
          w_state_next = S_IDLE;
        end else if (set_pw) begin
          w_state_next = S_NEWPW;
          w_idx_next   = '0;
        end else if (r_timer == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_timer_next = r_timer - TMR_W'(1);
        end
      end
      S_NEWPW: begin
        if (lock) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else if (clear) begin
          w_state_next = S_OPEN;
          w_timer_next = OPEN_LOAD;
          w_idx_next   = '0;
        end else if (digit_valid) begin
          // New passwords are keyed most-significant digit first, as the value reads in hex.
          w_shadow_next[IDX_LAST - r_idx] = digit_in;
          if (r_idx == IDX_LAST) begin
            w_pw_next    = w_shadow_next;
            w_state_next = S_OPEN;
            w_timer_next = OPEN_LOAD;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      S_ALARM: begin
        if (r_timer == '0) begin
          w_state_next = S_IDLE;
          w_fail_next  = '0;
        end else begin
          w_timer_next = r_timer - TMR_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
        w_mis_next   = 1'b0;
      end
    endcase

    if (w_eval) begin
      w_idx_next = '0;
      w_mis_next = 1'b0;
      if (!w_eval_mis) begin
        w_state_next = S_OPEN;
        w_fail_next  = '0;
        w_timer_next = OPEN_LOAD;
      end else if ((r_fail + FC_W'(1)) == FC_MAX) begin
        w_state_next = S_ALARM;
        w_fail_next  = FC_MAX;
        w_timer_next = ALARM_LOAD;
      end else begin
        w_state_next = S_IDLE;
        w_fail_next  = r_fail + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_mis      <= 1'b0;
      r_fail     <= '0;
      r_timer    <= '0;
      r_pw       <= DEFAULT_PW;
      r_shadow   <= '0;
      r_unlocked <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_mis      <= w_mis_next;
      r_fail     <= w_fail_next;
      r_timer    <= w_timer_next;
      r_pw       <= w_pw_next;
      r_shadow   <= w_shadow_next;
      r_unlocked <= (w_state_next == S_OPEN);
    end
  end

  assign state      = r_state;
  assign fail_count = r_fail;
  assign unlocked   = r_unlocked;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: a sequence-level reference model queues the expected
// outputs for every edge; a monitor pops and compares them one cycle later.
module tb_combo_lock_ctrl;

  localparam int          DIGITS      = 4;
  localparam int          DIGIT_W     = 4;
  localparam int          MAX_FAILS   = 3;
  localparam int          OPEN_TICKS  = 8;
  localparam int          ALARM_TICKS = 16;
  localparam logic [15:0] DEFAULT_PW  = 16'h1234;

  localparam int ST_IDLE  = 0;
  localparam int ST_ENTRY = 1;
  localparam int ST_ALARM = 2;
  localparam int ST_NEWPW = 3;
  localparam int ST_OPEN  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DIGIT_W-1:0] digit_in = '0;
  logic             digit_valid = 1'b0;
  logic             clear = 1'b0;
  logic             set_pw = 1'b0;
  logic             lock = 1'b0;
  logic [2:0]       state;
  logic [1:0]       fail_count;
  logic             unlocked;

  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAILS(MAX_FAILS),
    .OPEN_TICKS(OPEN_TICKS), .ALARM_TICKS(ALARM_TICKS), .DEFAULT_PW(DEFAULT_PW)
  ) dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .set_pw(set_pw), .lock(lock),
    .state(state), .fail_count(fail_count), .unlocked(unlocked)
  );

  int n_vec = 0;
  int n_mis = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_word;
  logic [5:0] got_word;

  // Reference model: keyed digits are collected whole and compared as a sequence.
  int m_mode, m_fails, m_open_left, m_alarm_left;
  int m_pw[DIGITS];
  int m_entry[$];
  int m_newq[$];

  task automatic model_reset();
    m_mode = ST_IDLE;
    m_fails = 0;
    m_open_left = 0;
    m_alarm_left = 0;
    m_entry.delete();
    m_newq.delete();
    for (int i = 0; i < DIGITS; i++) m_pw[i] = int'((DEFAULT_PW >> (DIGIT_W * i)) & 16'hF);
  endtask

  task automatic model_check_entry();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (m_entry[i] != m_pw[i]) ok = 1'b0;
    m_entry.delete();
    if (ok) begin
      m_mode = ST_OPEN;
      m_fails = 0;
      m_open_left = OPEN_TICKS;
    end else begin
      m_fails++;
      if (m_fails == MAX_FAILS) begin
        m_mode = ST_ALARM;
        m_alarm_left = ALARM_TICKS;
      end else begin
        m_mode = ST_IDLE;
      end
    end
  endtask

  task automatic model_edge(input bit dv, input int d, input bit clr, input bit sp,
                            input bit lk, input bit rst);
    if (rst) begin
      model_reset();
    end else begin
      case (m_mode)
        ST_IDLE, ST_ENTRY: begin
          if (clr) begin
            m_entry.delete();
            m_mode = ST_IDLE;
          end else if (dv) begin
            m_entry.push_back(d);
            if (m_entry.size() == DIGITS) model_check_entry();
            else m_mode = ST_ENTRY;
          end
        end
        ST_OPEN: begin
          if (lk) m_mode = ST_IDLE;
          else if (sp) begin
            m_mode = ST_NEWPW;
            m_newq.delete();
          end else begin
            m_open_left--;
            if (m_open_left == 0) m_mode = ST_IDLE;
          end
        end
        ST_NEWPW: begin
          if (lk) m_mode = ST_IDLE;
          else if (clr) begin
            m_mode = ST_OPEN;
            m_open_left = OPEN_TICKS;
          end else if (dv) begin
            m_newq.push_back(d);
            if (m_newq.size() == DIGITS) begin
              // Typed order reads most-significant digit first.
              for (int i = 0; i < DIGITS; i++) m_pw[DIGITS-1-i] = m_newq[i];
              m_mode = ST_OPEN;
              m_open_left = OPEN_TICKS;
            end
          end
        end
        ST_ALARM: begin
          m_alarm_left--;
          if (m_alarm_left == 0) begin
            m_mode = ST_IDLE;
            m_fails = 0;
          end
        end
        default: m_mode = ST_IDLE;
      endcase
    end
  endtask

  task automatic step(input bit dv, input int d, input bit clr, input bit sp,
                      input bit lk, input bit rst);
    logic [5:0] e;
    @(negedge clk);
    digit_valid = dv;
    digit_in    = DIGIT_W'(d);
    clear       = clr;
    set_pw      = sp;
    lock        = lk;
    reset       = rst;
    model_edge(dv, d, clr, sp, lk, rst);
    e = {3'(m_mode), 2'(m_fails), (m_mode == ST_OPEN)};
    exp_q.push_back(e);
    if (dv || clr || sp || lk || rst)
      $display("txn t=%0t dv=%0b d=%h clr=%0b set=%0b lock=%0b rst=%0b -> exp state=%0d fc=%0d unl=%0b",
               $time, dv, d[3:0], clr, sp, lk, rst, m_mode, m_fails, m_mode == ST_OPEN);
  endtask

  task automatic key(input int d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key4(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_word = exp_q.pop_front();
        got_word = {state, fail_count, unlocked};
        n_vec++;
        if (got_word !== exp_word)
          begin
            n_mis++;
            $display("FAIL outputs vec#%0d t=%0t: got state=%b fc=%0d unl=%b, expected state=%b fc=%0d unl=%b",
                     n_vec, $time, got_word[5:3], got_word[2:1], got_word[0],
                     exp_word[5:3], exp_word[2:1], exp_word[0]);
          end
      end
    end
  end

  initial begin
    int d;
    int r;
    model_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Open with default password, then time out.
    key4(4, 3, 2, 1);
    idle(10);
    // Three wrong sequences into alarm; keys during alarm are ignored.
    key4(4, 3, 2, 0); idle(1);
    key4(4, 3, 2, 0); idle(1);
    key4(4, 3, 2, 0);
    key4(4, 3, 2, 1);
    idle(14);
    // Clear abandons an entry without counting a failure.
    key(4); key(3); step(0, 0, 1, 0, 0, 0);
    key4(4, 3, 2, 1);
    // Password change, wrong old password, then the new one.
    step(0, 0, 0, 1, 0, 0);
    key4(9, 8, 7, 6);
    step(0, 0, 0, 0, 1, 0);
    key4(4, 3, 2, 1);
    key4(6, 7, 8, 9);
    // Aborted change keeps the old password; lock beats set_pw.
    step(0, 0, 0, 1, 0, 0);
    key(5); key(5); step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    key4(6, 7, 8, 9);
    step(0, 0, 0, 1, 1, 0);
    // Reset mid-change after a committed change restores the default password.
    key4(6, 7, 8, 9);
    step(0, 0, 0, 1, 0, 0);
    key4(1, 1, 1, 1);
    step(0, 0, 0, 1, 0, 0);
    key(2);
    step(0, 0, 0, 0, 0, 1);
    key4(4, 3, 2, 1);
    idle(10);
    // Randomized traffic, digits biased toward the current password.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if ((m_mode == ST_IDLE || m_mode == ST_ENTRY) && $urandom_range(0, 9) < 8)
        d = m_pw[m_entry.size()];
      else
        d = int'($urandom_range(0, 15));
      if (r < 1)       step(0, 0, 0, 0, 0, 1);
      else if (r < 45) step(1, d, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                            $urandom_range(0, 19) == 0, 0);
      else if (r < 50) step(0, 0, 1, 0, 0, 0);
      else if (r < 55) step(0, 0, 0, 0, 1, 0);
      else if (r < 63) step(0, 0, 0, 1, 0, 0);
      else             step(0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
